trace_request_responder: RTL
============================

Name: trace_request_responder

Overview:
Request-side responder for the n-way trace repository. It accepts memory requests from the repository's MAKE_REQUEST stage, each tagged with a trace index and address, and holds them in an in-order tracker table. It issues them to the data-memory port and returns each retired request to the repository with its hit/miss flag. It sits between the trace repository request logic and the cache/memory interface.

Parameters:
TRACE_ENTRIES, 131072, trace depth; IDX_W = $clog2(TRACE_ENTRIES) (local)
DATA_ADDR_WIDTH, 32, memory address width
TRACKER_DEPTH, 4, outstanding-request slots; power of two, >=2; CNT_W = $clog2(TRACKER_DEPTH+1) (local)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  repository request valid
req_ready  out  1  slot available
req_trace_index  in  IDX_W  trace index of request
req_mem_addr  in  DATA_ADDR_WIDTH  request address
mem_req  out  1  memory request
mem_addr  out  DATA_ADDR_WIDTH  memory address
mem_gnt  in  1  memory grant
mem_rvalid  in  1  memory response, in issue order
mem_hit  in  1  hit(1)/miss(0), valid with mem_rvalid
ret_valid  out  1  retired request valid
ret_ready  in  1  repository accepts retirement
ret_trace_index  out  IDX_W  retired trace index
ret_mem_addr  out  DATA_ADDR_WIDTH  retired address
ret_hit_miss  out  1  retired hit/miss flag
outstanding  out  CNT_W  occupied slot count
err_unexpected  out  1  sticky: rvalid with nothing in flight

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous, active-low. While rst_n=0, all slots clear, all pointers 0, and every output is 0 except req_ready=1.
- Slot fields: occupied, processing, done, hit, mem_addr, trace_index.
- Four pointers: alloc, issue, resp, retire. Each wraps modulo TRACKER_DEPTH.
- Accept:
  - req_ready = !occupied[alloc], taken from registered state only. A slot freed by a retirement is not reusable in the same cycle.
  - On req_valid && req_ready: write the slot, set occupied=1, processing=0, done=0, and advance alloc.
- Issue:
  - mem_req=1 and mem_addr=slot[issue].mem_addr when slot[issue] is occupied && !processing. Both are registered.
  - Earliest mem_req is the cycle after acceptance.
  - mem_req and mem_addr hold stable until mem_gnt. On mem_req && mem_gnt: set processing=1 and advance issue.
  - mem_req may re-assert for the next slot in the cycle after a grant.
- Response:
  - On mem_rvalid with slot[resp] processing && !done: set done=1, latch hit=mem_hit, advance resp.
  - An rvalid in the same cycle as its own slot's grant is not permitted; memory responds no earlier than the cycle after grant.
  - On mem_rvalid with no processing, not-done slot at resp: ignore it and set err_unexpected=1. It stays set until reset.
- Retire:
  - ret_valid=1 when slot[retire] is done. ret_* fields come from that slot, registered.
  - Earliest ret_valid is the cycle after mem_rvalid.
  - On ret_valid && ret_ready: clear occupied/processing/done and advance retire.
  - ret_* hold stable while ret_valid && !ret_ready.
- outstanding: number of occupied slots, registered. It takes +1 on accept and -1 on retire, and is unchanged when both happen in the same cycle. Range 0..TRACKER_DEPTH.
- Full: outstanding==TRACKER_DEPTH gives req_ready=0. Empty: mem_req=0 and ret_valid=0.
- Simultaneous accept, grant, response and retire in one cycle are all legal and independent.
- Duplicate addresses are not coalesced. Each request retires separately, in acceptance order.
- Reset mid-operation drops all slots. The memory side must be reset together with this block; stray rvalids after reset set err_unexpected.

Test Plan:
- Single request: idx=5, addr=0x1000, gnt the next cycle, rvalid hit=1 two cycles later -> mem_req 1 cycle after accept; ret_valid 1 cycle after rvalid with idx=5, addr=0x1000, hit=1; outstanding returns to 0.
- Fill: 4 back-to-back requests (idx 0..3) with mem_gnt=0 -> req_ready=0 after the 4th, outstanding=4, mem_req held with addr of idx 0.
- Order with backpressure: 4 requests, responses hit pattern 1,0,0,1, ret_ready=0 for 3 cycles -> ret fields stable while stalled; retirements in order 0,1,2,3 with flags 1,0,0,1.
- Wrap: 10 sequential requests through depth 4 -> all 10 indices retired in order, pointers wrap, no loss or duplication.
- Same-cycle events: accept, grant, rvalid and retire all in one cycle -> outstanding unchanged, each slot advances correctly.
- Error and reset: rvalid with empty tracker -> err_unexpected=1 and sticky; rst_n low mid-flight with 3 outstanding -> outstanding=0, req_ready=1, ret_valid=0, err cleared.

Source files
------------

// File: rtl/trace_request_responder.sv
// In-order request tracker between the trace repository and the data memory.
// Requests are issued, answered and retired strictly in acceptance order.
module trace_request_responder #(
  parameter int TRACE_ENTRIES   = 131072,
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int TRACKER_DEPTH   = 4,
  localparam int IDX_W = $clog2(TRACE_ENTRIES),
  localparam int CNT_W = $clog2(TRACKER_DEPTH + 1),
  localparam int PTR_W = $clog2(TRACKER_DEPTH)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [IDX_W-1:0]           req_trace_index,
  input  logic [DATA_ADDR_WIDTH-1:0] req_mem_addr,
  output logic                       mem_req,
  output logic [DATA_ADDR_WIDTH-1:0] mem_addr,
  input  logic                       mem_gnt,
  input  logic                       mem_rvalid,
  input  logic                       mem_hit,
  output logic                       ret_valid,
  input  logic                       ret_ready,
  output logic [IDX_W-1:0]           ret_trace_index,
  output logic [DATA_ADDR_WIDTH-1:0] ret_mem_addr,
  output logic                       ret_hit_miss,
  output logic [CNT_W-1:0]           outstanding,
  output logic                       err_unexpected
);

  logic [TRACKER_DEPTH-1:0] occ_q, occ_d;
  logic [TRACKER_DEPTH-1:0] prc_q, prc_d;
  logic [TRACKER_DEPTH-1:0] don_q, don_d;
  logic [TRACKER_DEPTH-1:0] hit_q, hit_d;
  logic [DATA_ADDR_WIDTH-1:0] addr_q [TRACKER_DEPTH];
  logic [DATA_ADDR_WIDTH-1:0] addr_d [TRACKER_DEPTH];
  logic [IDX_W-1:0] tidx_q [TRACKER_DEPTH];
  logic [IDX_W-1:0] tidx_d [TRACKER_DEPTH];

  logic [PTR_W-1:0] alloc_q, alloc_d;
  logic [PTR_W-1:0] issue_q, issue_d;
  logic [PTR_W-1:0] resp_q, resp_d;
  logic [PTR_W-1:0] retire_q, retire_d;

  logic                       mem_req_q, mem_req_d;
  logic [DATA_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                       ret_valid_q, ret_valid_d;
  logic [IDX_W-1:0]           ret_idx_q, ret_idx_d;
  logic [DATA_ADDR_WIDTH-1:0] ret_addr_q, ret_addr_d;
  logic                       ret_hit_q, ret_hit_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       err_q, err_d;

  logic acc;
  logic gnt;
  logic rsp;
  logic rsp_bad;
  logic ret;

  assign req_ready = !occ_q[alloc_q];
  assign acc       = req_valid && req_ready;
  assign gnt       = mem_req_q && mem_gnt;
  assign rsp       = mem_rvalid && prc_q[resp_q] && !don_q[resp_q];
  assign rsp_bad   = mem_rvalid && !rsp;
  assign ret       = ret_valid_q && ret_ready;

  // The four events touch disjoint slots, so their updates never collide.
  always_comb begin
    occ_d    = occ_q;
    prc_d    = prc_q;
    don_d    = don_q;
    hit_d    = hit_q;
    addr_d   = addr_q;
    tidx_d   = tidx_q;
    alloc_d  = alloc_q;
    issue_d  = issue_q;
    resp_d   = resp_q;
    retire_d = retire_q;

    if (acc) begin
      occ_d[alloc_q]  = 1'b1;
      prc_d[alloc_q]  = 1'b0;
      don_d[alloc_q]  = 1'b0;
      hit_d[alloc_q]  = 1'b0;
      addr_d[alloc_q] = req_mem_addr;
      tidx_d[alloc_q] = req_trace_index;
      alloc_d         = alloc_q + PTR_W'(1);
    end

    if (gnt) begin
      prc_d[issue_q] = 1'b1;
      issue_d        = issue_q + PTR_W'(1);
    end

    if (rsp) begin
      don_d[resp_q] = 1'b1;
      hit_d[resp_q] = mem_hit;
      resp_d        = resp_q + PTR_W'(1);
    end

    if (ret) begin
      occ_d[retire_q] = 1'b0;
      prc_d[retire_q] = 1'b0;
      don_d[retire_q] = 1'b0;
      retire_d        = retire_q + PTR_W'(1);
    end
  end

  // Outputs are registered views of the next slot state.
  always_comb begin
    cnt_d       = cnt_q + CNT_W'(acc) - CNT_W'(ret);
    err_d       = err_q | rsp_bad;
    mem_req_d   = occ_d[issue_d] && !prc_d[issue_d];
    mem_addr_d  = mem_req_d ? addr_d[issue_d] : '0;
    ret_valid_d = don_d[retire_d];
    ret_idx_d   = ret_valid_d ? tidx_d[retire_d] : '0;
    ret_addr_d  = ret_valid_d ? addr_d[retire_d] : '0;
    ret_hit_d   = ret_valid_d && hit_d[retire_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q       <= '0;
      prc_q       <= '0;
      don_q       <= '0;
      hit_q       <= '0;
      for (int i = 0; i < TRACKER_DEPTH; i++) begin
        addr_q[i] <= '0;
        tidx_q[i] <= '0;
      end
      alloc_q     <= '0;
      issue_q     <= '0;
      resp_q      <= '0;
      retire_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      ret_valid_q <= 1'b0;
      ret_idx_q   <= '0;
      ret_addr_q  <= '0;
      ret_hit_q   <= 1'b0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      occ_q       <= occ_d;
      prc_q       <= prc_d;
      don_q       <= don_d;
      hit_q       <= hit_d;
      addr_q      <= addr_d;
      tidx_q      <= tidx_d;
      alloc_q     <= alloc_d;
      issue_q     <= issue_d;
      resp_q      <= resp_d;
      retire_q    <= retire_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      ret_valid_q <= ret_valid_d;
      ret_idx_q   <= ret_idx_d;
      ret_addr_q  <= ret_addr_d;
      ret_hit_q   <= ret_hit_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
    end
  end

  assign mem_req         = mem_req_q;
  assign mem_addr        = mem_addr_q;
  assign ret_valid       = ret_valid_q;
  assign ret_trace_index = ret_idx_q;
  assign ret_mem_addr    = ret_addr_q;
  assign ret_hit_miss    = ret_hit_q;
  assign outstanding     = cnt_q;
  assign err_unexpected  = err_q;

endmodule
